fft_bin_reader: RTL and testbench

Unloads a completed 256-point in-place FFT frame from the FFT working memory and streams the first 128 complex bins in natural order (bin 0..127) to the spectral-flux stage. It reads the memory through the same synchronous-read port that the FFT address generator drives during butterfly passes. The two sides are muxed by the FFT controller, and this block owns the port only while `o_busy` is high. Output uses a valid/ready stream with a 2-entry buffer, so backpressure never loses or duplicates a bin.

---
 rtl/fft_bin_reader_if.sv | 36 +++
 rtl/fft_bin_reader.sv | 136 +++++++++++++
 tb/tb_fft_bin_reader.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fft_bin_reader_if.sv
// Bundles the FFT working-memory read port and the output bin stream of
// fft_bin_reader. Signal names keep the reader-side direction prefixes.
interface fft_bin_reader_if #(
    parameter int DATA_W = 16
);
    // Memory read port (synchronous read, data one cycle after strobe)
    logic              o_mem_rd_en;
    logic [7:0]        o_mem_addr;
    logic [DATA_W-1:0] i_mem_re;
    logic [DATA_W-1:0] i_mem_im;

    // Output stream. A bin transfers on any rising clock edge where
    // o_valid and i_ready are both high; once o_valid rises, o_bin_idx,
    // o_re, o_im and o_last hold until that transfer, and o_valid never
    // falls without it. i_ready may change freely.
    logic              o_valid;
    logic              i_ready;
    logic [6:0]        o_bin_idx;
    logic [DATA_W-1:0] o_re;
    logic [DATA_W-1:0] o_im;
    logic              o_last;

    modport master (
        output o_mem_rd_en, o_mem_addr,
        input  i_mem_re, i_mem_im,
        output o_valid, o_bin_idx, o_re, o_im, o_last,
        input  i_ready
    );

    modport slave (
        input  o_mem_rd_en, o_mem_addr,
        output i_mem_re, i_mem_im,
        input  o_valid, o_bin_idx, o_re, o_im, o_last,
        output i_ready
    );
endinterface

// File: rtl/fft_bin_reader.sv
// Unloads the first 128 bins of a finished 256-point in-place FFT frame
// in natural order. Bin k is read from address bitrev8(k); read data is
// buffered in a 2-entry FIFO so downstream backpressure never drops or
// repeats a bin. The memory port is owned only while o_busy is high.
module fft_bin_reader #(
    parameter int DATA_W = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    output logic              o_busy,
    output logic              o_done,
    output logic [1:0]        o_dbg_state,
    fft_bin_reader_if.master  bus
);
    localparam int ADDR_W   = 8;
    localparam int NUM_BINS = 128;
    localparam logic [6:0] LAST_K = 7'(NUM_BINS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                state_q;
    logic [6:0]            rd_k_q;
    logic [6:0]            out_k_q;
    logic                  inflight_q;
    logic [2*DATA_W-1:0]   fifo_q [2];
    logic                  wr_ptr_q;
    logic                  rd_ptr_q;
    logic [1:0]            count_q;
    logic [1:0]            count_d;
    logic                  done_q;

    logic                  fifo_valid;
    logic                  pop;
    logic [2:0]            occ;
    logic                  rd_en;
    logic [ADDR_W-1:0]     addr_rev;

    assign fifo_valid = (count_q != 2'd0);
    assign pop        = fifo_valid & bus.i_ready;

    // Bit-reversed address: bit i of the address is bit (7-i) of k; k is
    // below 128 so address bit 0 is always zero.
    assign addr_rev = {rd_k_q[0], rd_k_q[1], rd_k_q[2], rd_k_q[3],
                       rd_k_q[4], rd_k_q[5], rd_k_q[6], 1'b0};

    // Issue a read only if the FIFO can still hold it once it returns:
    // entries held plus the one in flight, less the one leaving now.
    always_comb begin
        occ     = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
        rd_en   = (state_q == S_READ) && (occ < 3'd2);
        count_d = count_q + {1'b0, inflight_q} - {1'b0, pop};
    end

    // Frame FSM, counters, FIFO storage and the done pulse
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= S_IDLE;
            rd_k_q     <= '0;
            out_k_q    <= '0;
            inflight_q <= 1'b0;
            fifo_q[0]  <= '0;
            fifo_q[1]  <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            count_q    <= '0;
            done_q     <= 1'b0;
        end else begin
            done_q     <= 1'b0;
            inflight_q <= rd_en;
            count_q    <= count_d;

            // Returning read data always has room, so push unconditionally
            if (inflight_q) begin
                fifo_q[wr_ptr_q] <= {bus.i_mem_re, bus.i_mem_im};
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end

            case (state_q)
                S_IDLE: begin
                    if (i_start) begin
                        state_q <= S_READ;
                        rd_k_q  <= '0;
                        out_k_q <= '0;
                    end
                end
                S_READ: begin
                    if (rd_en) begin
                        if (rd_k_q == LAST_K) begin
                            state_q <= S_DRAIN;
                        end else begin
                            rd_k_q <= rd_k_q + 7'd1;
                        end
                    end
                    // Bin 127 cannot be popped before its read is issued,
                    // so this increment never wraps.
                    if (pop) begin
                        out_k_q <= out_k_q + 7'd1;
                    end
                end
                S_DRAIN: begin
                    if (pop) begin
                        if (out_k_q == LAST_K) begin
                            state_q <= S_IDLE;
                            done_q  <= 1'b1;
                        end else begin
                            out_k_q <= out_k_q + 7'd1;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign o_busy          = (state_q != S_IDLE);
    assign o_done          = done_q;
    assign o_dbg_state     = state_q;

    assign bus.o_mem_rd_en = rd_en;
    assign bus.o_mem_addr  = (state_q == S_READ) ? addr_rev : '0;
    assign bus.o_valid     = fifo_valid;
    assign bus.o_bin_idx   = out_k_q;
    assign bus.o_re        = fifo_q[rd_ptr_q][2*DATA_W-1:DATA_W];
    assign bus.o_im        = fifo_q[rd_ptr_q][DATA_W-1:0];
    assign bus.o_last      = fifo_valid && (out_k_q == LAST_K);
endmodule

// File: tb/tb_fft_bin_reader.sv
// Bench for fft_bin_reader: synchronous-read memory model holding
// re=addr, im=~addr, an expected-bin queue filled at each start and
// drained on every observed handshake, plus per-cycle timing checks.
module tb_fft_bin_reader;
    localparam int DATA_W = 16;
    localparam int W      = 1 + 7 + 2 * DATA_W;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;
    logic start;
    logic busy;
    logic done;
    logic [1:0] dbg_state;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    fft_bin_reader_if #(.DATA_W(DATA_W)) bus ();

    fft_bin_reader #(.DATA_W(DATA_W)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_start     (start),
        .o_busy      (busy),
        .o_done      (done),
        .o_dbg_state (dbg_state),
        .bus         (bus)
    );

    // Synchronous-read memory model: data valid one cycle after the strobe
    logic [DATA_W-1:0] mem_re_q;
    logic [DATA_W-1:0] mem_im_q;
    initial begin
        mem_re_q = '0;
        mem_im_q = '0;
    end
    always @(posedge clk) begin
        if (bus.o_mem_rd_en) begin
            mem_re_q <= DATA_W'(bus.o_mem_addr);
            mem_im_q <= ~DATA_W'(bus.o_mem_addr);
        end
    end
    assign bus.i_mem_re = mem_re_q;
    assign bus.i_mem_im = mem_im_q;

    // ---------------- scoreboard state ----------------
    logic [W-1:0] exp_q[$];
    int n_checks = 0;
    int n_errors = 0;
    int rd_cnt   = 0;
    int pop_cnt  = 0;
    bit mon_en   = 0;
    bit prev_stall = 0;
    logic [W-1:0] prev_obs;
    logic [W-1:0] obs;
    logic [W-1:0] exp_v;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] bitrev8(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = v[7-i];
        return r;
    endfunction

    function automatic logic [W-1:0] exp_bin(input int k);
        logic [7:0]        a;
        logic [DATA_W-1:0] re;
        a  = bitrev8(8'(k));
        re = DATA_W'(a);
        return {(k == 127), 7'(k), re, ~re};
    endfunction

    // Monitor: read addresses, occupancy, stall stability, bin data
    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            obs = {bus.o_last, bus.o_bin_idx, bus.o_re, bus.o_im};
            if (busy) check_eq("occupancy_le2", 64'((rd_cnt - pop_cnt) <= 2), 64'd1);
            if (prev_stall) begin
                check_eq("hold_valid", 64'(bus.o_valid), 64'd1);
                check_eq("hold_data", 64'(obs), 64'(prev_obs));
            end
            if (bus.o_mem_rd_en) begin
                check_eq("rd_addr", 64'(bus.o_mem_addr), 64'(bitrev8(8'(rd_cnt))));
                rd_cnt++;
            end
            if (bus.o_valid && bus.i_ready) begin
                check_eq("exp_q_nonempty", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    exp_v = exp_q.pop_front();
                    check_eq("bin", 64'(obs), 64'(exp_v));
                end
                pop_cnt++;
            end
            prev_stall = bus.o_valid && !bus.i_ready;
            prev_obs   = obs;
        end else begin
            prev_stall = 0;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives a start for the edge ending the current cycle (cycle 0);
    // returns just after the edge that begins cycle 1.
    task automatic start_frame();
        rd_cnt  = 0;
        pop_cnt = 0;
        mon_en  = 1;
        for (int k = 0; k < 128; k++) exp_q.push_back(exp_bin(k));
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Full-rate frame with cycle-exact checks; optional extra start pulses.
    // Returns at the falling edge of cycle 131.
    task automatic run_full(input int s1, input int s2);
        bus.i_ready = 1'b1;
        start_frame();
        for (int c = 1; c <= 131; c++) begin
            @(negedge clk);
            check_eq("busy_t",  64'(busy),            64'(c <= 130));
            check_eq("rd_en_t", 64'(bus.o_mem_rd_en), 64'(c <= 128));
            check_eq("valid_t", 64'(bus.o_valid),     64'(c >= 3 && c <= 130));
            check_eq("last_t",  64'(bus.o_last),      64'(c == 130));
            check_eq("done_t",  64'(done),            64'(c == 131));
            if (c < 131) begin
                if (c == s1 || c == s2) start = 1'b1;
                tick();
                start = 1'b0;
            end
        end
    endtask

    task automatic wait_done(input int bound);
        bit seen;
        seen = 0;
        for (int i = 0; i < bound && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1;
            tick();
        end
        check_eq("done_seen", 64'(seen), 64'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_busy"},  64'(busy),            64'd0);
        check_eq({tag, "_rd_en"}, 64'(bus.o_mem_rd_en), 64'd0);
        check_eq({tag, "_addr"},  64'(bus.o_mem_addr),  64'd0);
        check_eq({tag, "_valid"}, 64'(bus.o_valid),     64'd0);
        check_eq({tag, "_idx"},   64'(bus.o_bin_idx),   64'd0);
        check_eq({tag, "_re"},    64'(bus.o_re),        64'd0);
        check_eq({tag, "_im"},    64'(bus.o_im),        64'd0);
        check_eq({tag, "_last"},  64'(bus.o_last),      64'd0);
        check_eq({tag, "_done"},  64'(done),            64'd0);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        rst_n       = 1'b0;
        start       = 1'b0;
        bus.i_ready = 1'b0;
        @(negedge clk);
        check_all_zero("reset");
        tick();
        rst_n = 1'b1;
        tick();

        // Throughput
        run_full(0, 0);
        check_eq("tp_queue_empty", 64'(exp_q.size()), 64'd0);
        tick();

        // Backpressure at 50%
        bus.i_ready = 1'b0;
        start_frame();
        begin
            bit got;
            got = 0;
            for (int i = 0; i < 2000 && !got; i++) begin
                bus.i_ready = 1'($urandom_range(0, 1));
                @(negedge clk);
                if (done) got = 1;
                tick();
            end
            check_eq("bp_done", 64'(got), 64'd1);
        end
        check_eq("bp_queue_empty", 64'(exp_q.size()), 64'd0);
        check_eq("bp_pops", 64'(pop_cnt), 64'd128);

        // Ready stuck low for 20 cycles
        bus.i_ready = 1'b0;
        start_frame();
        repeat (20) tick();
        @(negedge clk);
        check_eq("stuck_rd_pulses", 64'(rd_cnt), 64'd2);
        check_eq("stuck_valid",     64'(bus.o_valid), 64'd1);
        check_eq("stuck_idx",       64'(bus.o_bin_idx), 64'd0);
        tick();
        bus.i_ready = 1'b1;
        for (int i = 0; i < 128; i++) begin
            @(negedge clk);
            check_eq("resume_valid", 64'(bus.o_valid), 64'd1);
            tick();
        end
        wait_done(4);
        check_eq("stuck_queue_empty", 64'(exp_q.size()), 64'd0);
        tick();

        // Start while busy
        run_full(5, 60);
        check_eq("sb_queue_empty", 64'(exp_q.size()), 64'd0);
        tick();

        // Reset mid-frame
        bus.i_ready = 1'b1;
        start_frame();
        repeat (39) tick();
        mon_en = 0;
        rst_n  = 1'b0;
        #1;
        check_all_zero("midrst");
        exp_q.delete();
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("midrst_no_done", 64'(done), 64'd0);
            check_eq("midrst_idle",    64'(busy), 64'd0);
            tick();
        end
        run_full(0, 0);
        check_eq("rst_queue_empty", 64'(exp_q.size()), 64'd0);

        // Back-to-back: second start on cycle 131 of the previous frame
        run_full(0, 0);
        check_eq("b2b_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog act=running exp=finished");
        $fatal(1, "watchdog");
    end
endmodule
